// File: rtl/mul_fsm.sv
// mul_fsm: sequencing FSM plus ripple-carry adder for an 8x8 shift-add
// multiplier. The parent owns the product and multiplier registers; this
// block tells it each cycle whether to load, add-and-shift, shift or hold.

// One full-adder bit of the ripple chain.
module mul_fsm_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module mul_fsm #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] multiplier,
  output logic [1:0]       state,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  input  logic             add_cin,
  output logic [WIDTH-1:0] add_sum,
  output logic             add_cout
);

  typedef enum logic [1:0] {
    P_INIT = 2'd0,
    P_RUN  = 2'd1,
    P_HALT = 2'd2
  } phase_t;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_IDLE = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  phase_t           r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Only bit 0 of the shifting multiplier steers the step code.
  logic w_unused;
  assign w_unused = &{1'b0, multiplier[WIDTH-1:1]};

  // Phase and iteration counter registers; reset restarts the sequence.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_phase <= P_INIT;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-phase logic and step code; EXEC vs IDLE follows the current
  // multiplier LSB with no added latency.
  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    state       = S_INIT;
    case (r_phase)
      P_INIT: begin
        state       = S_INIT;
        w_phase_nxt = P_RUN;
        w_cnt_nxt   = '0;
      end
      P_RUN: begin
        state = multiplier[0] ? S_EXEC : S_IDLE;
        if (r_cnt == LAST) begin
          w_phase_nxt = P_HALT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      P_HALT: begin
        state = S_HALT;
      end
      default: begin
        state       = S_INIT;
        w_phase_nxt = P_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Ripple-carry adder, independent of phase and reset.
  logic [WIDTH:0] w_c;
  assign w_c[0] = add_cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      mul_fsm_fa u_fa (
        .i_a (add_a[gi]),
        .i_b (add_b[gi]),
        .i_c (w_c[gi]),
        .o_s (add_sum[gi]),
        .o_c (w_c[gi+1])
      );
    end
  endgenerate

  assign add_cout = w_c[WIDTH];

endmodule

// File: tb/tb_mul_fsm.sv
// tb_mul_fsm: directed bench with a parent datapath model and a queue of
// expected step codes derived from the multiplier operand bits.
module tb_mul_fsm;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] multiplier = '0;
  logic [7:0] add_a = '0;
  logic [7:0] add_b = '0;
  logic       add_cin = 1'b0;
  logic [1:0] state;
  logic [7:0] add_sum;
  logic       add_cout;

  int total = 0;
  int bad = 0;
  int runcnt = 0;

  logic [1:0]  sb[$];
  logic [15:0] prod = '0;
  logic [7:0]  rb = '0;
  logic [7:0]  mcand = '0;
  logic [7:0]  ld_b = '0;

  always #5 clk = ~clk;

  mul_fsm #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .areset     (areset),
    .multiplier (multiplier),
    .state      (state),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    multiplier = rb;
    add_a      = prod[15:8];
    add_b      = mcand;
    add_cin    = 1'b0;
  endtask

  // One clock: compare mid-cycle, act as the parent, then update after the edge.
  task automatic tick();
    logic [15:0] pn;
    logic [7:0]  bn;
    logic [1:0]  e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("state", 32'(state), 32'(e));
    end
    if (state == 2'd1 || state == 2'd2) runcnt++;
    pn = prod;
    bn = rb;
    case (state)
      2'd0: begin pn = '0; bn = ld_b; end
      2'd1: begin pn = {add_cout, add_sum, prod[7:1]}; bn = rb >> 1; end
      2'd2: begin pn = prod >> 1; bn = rb >> 1; end
      default: ;
    endcase
    @(posedge clk);
    #1;
    prod = pn;
    rb   = bn;
    drive();
  endtask

  task automatic push_run(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sb.push_back(b[i] ? 2'd1 : 2'd2);
  endtask

  task automatic adder_vec(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] es, input logic ec);
    add_a = a; add_b = b; add_cin = c;
    #1;
    check("add_sum", 32'(add_sum), 32'(es));
    check("add_cout", 32'(add_cout), 32'(ec));
  endtask

  // Full multiplication from a one-edge reset pulse.
  task automatic mul_run(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ep;
    ep = 16'(a) * 16'(b);
    mcand = a; ld_b = b;
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    drive();
    runcnt = 0;
    sb.push_back(2'd0);
    push_run(b);
    sb.push_back(2'd3);
    sb.push_back(2'd3);
    repeat (11) tick();
    check("runcnt", 32'(runcnt), 32'd8);
    check("product", 32'(prod), 32'(ep));
    repeat (2) begin sb.push_back(2'd3); tick(); end
    check("product_hold", 32'(prod), 32'(ep));
  endtask

  initial begin
    // Adder vectors
    adder_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    adder_vec(8'h7F, 8'h80, 1'b1, 8'h00, 1'b1);
    adder_vec(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    adder_vec(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);

    // Step sequence for 0xA5, then HALT held
    mul_run(8'h03, 8'hA5);

    // multiplier changes while halted have no effect
    rb = 8'h55; drive();
    sb.push_back(2'd3); tick();
    rb = 8'hFF; drive();
    sb.push_back(2'd3); tick();

    // All-zero multiplier: eight IDLE steps
    mul_run(8'h5A, 8'h00);

    // Integrated products
    mul_run(8'd13, 8'd11);
    mul_run(8'hFF, 8'hFF);
    mul_run(8'h80, 8'h02);

    // Reset on the 4th RUN cycle, then a full restart
    mcand = 8'd9; ld_b = 8'h6B;
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    drive();
    sb.push_back(2'd0);
    for (int i = 0; i < 3; i++) sb.push_back(ld_b[i] ? 2'd1 : 2'd2);
    repeat (4) tick();
    sb.push_back(ld_b[3] ? 2'd1 : 2'd2);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    runcnt = 0;
    sb.push_back(2'd0);
    push_run(ld_b);
    sb.push_back(2'd3);
    repeat (10) tick();
    check("midrst_runcnt", 32'(runcnt), 32'd8);
    check("midrst_product", 32'(prod), 32'(16'd9 * 16'h6B));

    // Reset held several cycles: INIT throughout plus one after release
    mcand = 8'd7; ld_b = 8'hC3;
    areset = 1'b1;
    @(posedge clk);
    #1;
    drive();
    repeat (3) begin sb.push_back(2'd0); tick(); end
    areset = 1'b0;
    runcnt = 0;
    sb.push_back(2'd0);
    push_run(ld_b);
    sb.push_back(2'd3);
    repeat (10) tick();
    check("heldrst_runcnt", 32'(runcnt), 32'd8);
    check("heldrst_product", 32'(prod), 32'(16'd7 * 16'hC3));

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_fsm.md
Name: mul_fsm

Overview:
- Control-plus-arithmetic core for the 8x8 shift-add sequential multiplier.
- Holds the sequencing FSM and the 8-bit adder.
- The FSM tells the parent datapath, per cycle, whether to load, add-and-shift, shift-only or hold.
- The adder forms {carry, sum} = product_hi + multiplicand for the add-and-shift step.
- Parent owns the product and multiplier shift registers and feeds back the current multiplier register.

Parameters:
- WIDTH, 8, operand width of the adder and the multiplier register; iteration count equals WIDTH.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- areset  input  1  reset
- multiplier  input  WIDTH  parent's current (shifting) multiplier register B; only bit 0 steers the FSM
- state  output  2  step code for the parent: 0=INIT, 1=EXEC, 2=IDLE, 3=HALT
- add_a  input  WIDTH  adder operand A (parent drives product[15:8])
- add_b  input  WIDTH  adder operand B (parent drives multiplicand)
- add_cin  input  1  adder carry-in (parent ties to 0)
- add_sum  output  WIDTH  add_a + add_b + add_cin, low WIDTH bits
- add_cout  output  1  carry out of the addition

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset areset is synchronous and active-high.
  - While areset is sampled high at a rising edge: phase <= P_INIT, cnt <= 0.
- Internal registers:
  - phase, 2 bits: P_INIT, P_RUN, P_HALT.
  - cnt, CNT_W bits.
- state output (combinational from phase and multiplier[0], no added latency):
  - P_INIT -> 0 (INIT).
  - P_HALT -> 3 (HALT).
  - P_RUN -> 1 (EXEC) if multiplier[0]=1, else 2 (IDLE).
- Transitions (rising edge, areset low):
  - P_INIT -> P_RUN, cnt <= 0. INIT is therefore visible for exactly one cycle after reset release; the parent loads B and clears product on it.
  - P_RUN, cnt < WIDTH-1 -> stay in P_RUN, cnt <= cnt+1.
  - P_RUN, cnt = WIDTH-1 -> P_HALT.
  - Exactly WIDTH (8) EXEC/IDLE cycles occur per multiplication.
  - P_HALT -> P_HALT. Held indefinitely; only areset restarts.
- Parent contract, per cycle, keyed on state:
  - INIT: load B, clear product.
  - EXEC: product <= {add_cout, add_sum, product[7:1]}, B >>= 1.
  - IDLE: product >>= 1, B >>= 1.
  - HALT: hold.
  - Because B shifts every RUN cycle, multiplier[0] presents successive multiplier bits LSB first.
- Adder:
  - Purely combinational: {add_cout, add_sum} = add_a + add_b + add_cin, full WIDTH+1-bit result, no truncation of carry.
  - Built as a ripple chain of WIDTH full adders (sum = a^b^c, carry = ab|ac|bc).
  - Independent of phase and reset.
- Boundary conditions:
  - Reset mid-run: next edge forces P_INIT/INIT regardless of cnt; the partial result is abandoned.
  - Reset held multiple cycles: INIT held throughout, then exactly one more INIT cycle after release.
  - multiplier changing during P_INIT/P_HALT: no effect on state.
  - After power-up without reset, state is undefined. Reset is mandatory.

Test Plan:
- Adder vectors: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0x7F, b=0x80, cin=1 -> sum=0x00, cout=1. a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
- Reset then release with B modelled as the shift register loaded with 0xA5 in INIT -> state sequence INIT, EXEC, IDLE, EXEC, IDLE, IDLE, EXEC, IDLE, EXEC, then HALT forever.
- multiplier held 0x00 -> INIT, then 8 IDLE, then HALT. Count exactly 8 non-INIT/non-HALT cycles.
- Reset asserted at 4th RUN cycle for one edge -> state=INIT next cycle, then a full 8-step run, then HALT.
- Integrated with the parent-model datapath:
  - multiplicand=13, multiplier=11 -> product=143 (0x008F) at HALT, held steady.
  - 255x255 -> 65025 (0xFE01).
  - 0x80x0x02 -> 0x0100.
